// File: rtl/sram_ctrl_timed.sv
// Single-port async SRAM controller with configurable read strobe and write pulse lengths.
// Writes frame the WE pulse with one setup and one hold cycle of driven data.
module sram_ctrl_timed #(
    parameter  int ADDR_WIDTH = 20,
    parameter  int DATA_WIDTH = 32,
    parameter  int RD_CYCLES  = 1,
    parameter  int WR_CYCLES  = 1,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [BE_WIDTH-1:0]   ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);

    if (RD_CYCLES < 1 || RD_CYCLES > 15 || WR_CYCLES < 1 || WR_CYCLES > 15 || DATA_WIDTH % 8 != 0) begin : g_param_check
        $error("sram_ctrl_timed: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept, capture, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [BE_WIDTH-1:0]   be_n_q;
    logic                  ce_n_q, oe_n_q, we_n_q, drive_q, rsp_valid_q;

    assign req_ready = (state_q == IDLE) && rst;
    assign accept    = req_valid && req_ready;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_we ? WR_SETUP : READ;
                    cnt_d   = RD_LOAD;
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    capture     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = WR_LOAD;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the pins never glitch on decode.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_n_q      <= '1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            ce_n_q      <= (state_d == IDLE);
            oe_n_q      <= (state_d != READ);
            we_n_q      <= (state_d != WR_PULSE);
            drive_q     <= (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_n_q  <= ~req_be;
            end else if (state_d == IDLE) begin
                be_n_q  <= '1;
            end
            if (capture) rdata_q <= ram_data;
        end
    end

    assign ram_data  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_addr  = addr_q;
    assign ram_be_n  = be_n_q;
    assign ram_ce_n  = ce_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl_timed.sv
// Self-checking bench for sram_ctrl_timed: a pin-level SRAM device model plus a
// request-level memory scoreboard; timing expectations come from the strobe-length rules.
module tb_sram_ctrl_timed;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int RD = 3;
    localparam int WR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [BW-1:0] req_be = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    wire  [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_be_n;
    logic          ram_ce_n, ram_oe_n, ram_we_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_ctrl_timed #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_be_n(ram_be_n),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return 32'(a) * 32'h9E37_79B9 + 32'h0123_4567;
    endfunction

    // Pin-level SRAM device: writes while CE and WE are low, drives data while CE and OE are low.
    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    logic [DW-1:0] dev_rd = '0;
    logic [DW-1:0] dev_w;
    bit            clash_seen = 1'b0;

    function automatic logic [DW-1:0] dev_get(input logic [AW-1:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    assign ram_data = (!ram_ce_n && !ram_oe_n) ? dev_rd : {DW{1'bz}};

    always @(negedge clk) begin
        if (!ram_ce_n && !ram_we_n) begin
            dev_w = dev_get(ram_addr);
            for (int b = 0; b < BW; b++)
                if (!ram_be_n[b]) dev_w[8*b +: 8] = ram_data[8*b +: 8];
            dev_mem[ram_addr] = dev_w;
        end
        dev_rd = dev_get(ram_addr);
        if (dut.drive_q && !ram_oe_n) clash_seen = 1'b1;
    end

    // Request-level scoreboard of what memory should hold.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        logic [DW-1:0] v;
        v = ref_get(a);
        for (int b = 0; b < BW; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = v;
    endtask

    // Issues one request (entered just after a negedge) and records what the pins did until rsp_valid.
    task automatic run_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [BW-1:0] be, output int lat, output logic [DW-1:0] rd,
                          output int oe_c, output int we_c, output int drv_c, output int ce_c,
                          output int first_we, output bit stable_ok, output bit gap_ok, output bit to);
        int w;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        to = (w >= 50);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom);
        req_wdata = $urandom; req_be = BW'($urandom);
        lat = 0; oe_c = 0; we_c = 0; drv_c = 0; ce_c = 0; first_we = 0;
        stable_ok = 1'b1; gap_ok = 1'b0; rd = '0;
        while (lat < 60) begin
            @(negedge clk); lat++;
            if (rsp_valid) begin
                rd = rsp_rdata;
                gap_ok = ram_ce_n && ram_oe_n && ram_we_n && !dut.drive_q;
                break;
            end
            if (!ram_oe_n) oe_c++;
            if (!ram_ce_n) ce_c++;
            if (dut.drive_q) drv_c++;
            if (!ram_we_n) begin we_c++; if (first_we == 0) first_we = lat; end
            if (ram_addr !== a || ram_be_n !== ~be) stable_ok = 1'b0;
        end
        if (lat >= 60) to = 1'b1;
        if (we) ref_write(a, wd, be);
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00055;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        total++; if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin bad++; $display("FAIL reset_strobes got=%b exp=111", {ram_ce_n, ram_oe_n, ram_we_n}); end
        total++; if (ram_be_n !== 4'hF) begin bad++; $display("FAIL reset_be_n got=%h exp=f", ram_be_n); end
        total++; if (dut.drive_q !== 1'b0) begin bad++; $display("FAIL reset_data_drive got=%b exp=0", dut.drive_q); end
        total++; if ({rsp_valid, rsp_rdata, ram_addr} !== '0) begin bad++; $display("FAIL reset_rsp_addr got=%b/%h/%h exp=0", rsp_valid, rsp_rdata, ram_addr); end
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_single_read();
        int lat, oe_c, we_c, drv_c, ce_c, fw; bit st, gp, to; logic [DW-1:0] rd;
        dev_mem[20'h00010] = 32'hDEAD_BEEF;
        ref_mem[20'h00010] = 32'hDEAD_BEEF;
        run_op(1'b0, 20'h00010, '0, 4'hF, lat, rd, oe_c, we_c, drv_c, ce_c, fw, st, gp, to);
        total++; if (to) begin bad++; $display("FAIL read_timeout got=timeout exp=rsp"); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data got=%h exp=deadbeef", rd); end
        total++; if (lat !== RD + 1) begin bad++; $display("FAIL read_latency got=%0d exp=%0d", lat, RD + 1); end
        total++; if (oe_c !== RD || ce_c !== RD) begin bad++; $display("FAIL read_strobe_len got=oe%0d/ce%0d exp=%0d", oe_c, ce_c, RD); end
        total++; if (drv_c !== 0 || we_c !== 0) begin bad++; $display("FAIL read_no_drive got=drv%0d/we%0d exp=0", drv_c, we_c); end
        total++; if (!st || !gp) begin bad++; $display("FAIL read_stable_gap got=%b/%b exp=1/1", st, gp); end
    endtask

    task automatic test_masked_write();
        int lat, oe_c, we_c, drv_c, ce_c, fw; bit st, gp, to; logic [DW-1:0] rd, old, exp;
        old = ref_get(20'h00020);
        exp = {old[31:16], 16'h5678};
        run_op(1'b1, 20'h00020, 32'h1234_5678, 4'b0011, lat, rd, oe_c, we_c, drv_c, ce_c, fw, st, gp, to);
        total++; if (to) begin bad++; $display("FAIL write_timeout got=timeout exp=rsp"); end
        total++; if (lat !== WR + 3) begin bad++; $display("FAIL write_latency got=%0d exp=%0d", lat, WR + 3); end
        total++; if (we_c !== WR || fw !== 2) begin bad++; $display("FAIL write_pulse got=len%0d/start%0d exp=len%0d/start2", we_c, fw, WR); end
        total++; if (drv_c !== WR + 2 || ce_c !== WR + 2 || oe_c !== 0) begin bad++; $display("FAIL write_frame got=drv%0d/ce%0d/oe%0d exp=%0d/%0d/0", drv_c, ce_c, oe_c, WR + 2, WR + 2); end
        total++; if (!st || !gp) begin bad++; $display("FAIL write_stable_gap got=%b/%b exp=1/1", st, gp); end
        run_op(1'b0, 20'h00020, '0, 4'hF, lat, rd, oe_c, we_c, drv_c, ce_c, fw, st, gp, to);
        total++; if (rd !== exp) begin bad++; $display("FAIL masked_readback got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a; logic [DW-1:0] wd, exp, rd; int c, rsp1, rsp2, oe1; bit gap;
        a = 20'h00006; wd = $urandom;
        ref_write(a, wd, 4'hF);
        exp = ref_get(a);
        clash_seen = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = wd; req_be = 4'hF;
        @(posedge clk); #1;
        req_we = 1'b0; req_addr = a; req_wdata = '0;
        c = 0; rsp1 = 0; rsp2 = 0; oe1 = 0; gap = 1'b0; rd = '0;
        while (c < 60 && rsp2 == 0) begin
            @(negedge clk); c++;
            if (rsp_valid && rsp1 == 0) begin
                rsp1 = c;
                gap = ram_ce_n && ram_oe_n && ram_we_n && !dut.drive_q;
            end else if (rsp_valid) begin
                rsp2 = c; rd = rsp_rdata;
            end
            if (!ram_oe_n && oe1 == 0) oe1 = c;
            if (rsp1 != 0 && c == rsp1 + 1) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        total++; if (rsp1 !== WR + 3) begin bad++; $display("FAIL b2b_write_rsp got=%0d exp=%0d", rsp1, WR + 3); end
        total++; if (oe1 !== WR + 4) begin bad++; $display("FAIL b2b_read_start got=%0d exp=%0d", oe1, WR + 4); end
        total++; if (rsp2 !== WR + 3 + RD + 1) begin bad++; $display("FAIL b2b_read_rsp got=%0d exp=%0d", rsp2, WR + RD + 4); end
        total++; if (!gap) begin bad++; $display("FAIL b2b_idle_gap got=0 exp=1"); end
        total++; if (rd !== exp) begin bad++; $display("FAIL b2b_read_data got=%h exp=%h", rd, exp); end
        total++; if (clash_seen) begin bad++; $display("FAIL b2b_bus_clash got=1 exp=0"); end
    endtask

    task automatic test_reset_mid_write();
        int w, rsp_seen;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'hFFFFF; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        @(posedge clk); #1; req_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (ram_we_n && w < 20);
        total++; if (ram_we_n !== 1'b0) begin bad++; $display("FAIL midrst_pulse_seen got=%b exp=0", ram_we_n); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if ({ram_we_n, ram_ce_n, dut.drive_q, req_ready} !== 4'b1100) begin bad++; $display("FAIL midrst_abort got=%b exp=1100", {ram_we_n, ram_ce_n, dut.drive_q, req_ready}); end
        @(negedge clk); rst = 1'b1;
        rsp_seen = 0;
        repeat (10) begin @(negedge clk); if (rsp_valid) rsp_seen++; end
        total++; if (rsp_seen !== 0) begin bad++; $display("FAIL midrst_no_rsp got=%0d exp=0", rsp_seen); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a; logic [DW-1:0] rd; int c; bit done;
        a = AW'($urandom_range(0, 15));
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(posedge clk); #1;
        c = 0; done = 1'b0; rd = '0;
        while (c < 40 && !done) begin
            @(negedge clk); c++;
            if (rsp_valid) begin
                req_valid = 1'b0; rd = rsp_rdata; done = 1'b1;
            end else begin
                total++; if (req_ready !== 1'b0 || ram_addr !== a) begin bad++; $display("FAIL bp_hold got=rdy%b/%h exp=rdy0/%h", req_ready, ram_addr, a); end
                req_addr = AW'($urandom); req_we = 1'($urandom);
            end
        end
        req_valid = 1'b0;
        total++; if (c !== RD + 1) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", c, RD + 1); end
        total++; if (rd !== ref_get(a)) begin bad++; $display("FAIL bp_read_data got=%h exp=%h", rd, ref_get(a)); end
        @(negedge clk);
        total++; if (ram_ce_n !== 1'b1) begin bad++; $display("FAIL bp_no_extra_accept got=%b exp=1", ram_ce_n); end
    endtask

    task automatic test_random();
        int lat, oe_c, we_c, drv_c, ce_c, fw; bit st, gp, to;
        logic we; logic [AW-1:0] a; logic [DW-1:0] wd, rd, exp; logic [BW-1:0] be;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom); a = AW'($urandom_range(0, 15)); wd = $urandom; be = BW'($urandom);
            if (i == 5) begin we = 1'b1; be = '0; end
            exp = ref_get(a);
            run_op(we, a, wd, be, lat, rd, oe_c, we_c, drv_c, ce_c, fw, st, gp, to);
            total++;
            if (to || lat !== (we ? WR + 3 : RD + 1) || !st || !gp) begin
                bad++; $display("FAIL rand_timing op=%0d we=%b got=lat%0d/st%b/gap%b/to%b", i, we, lat, st, gp, to);
            end
            if (!we) begin
                total++; if (rd !== exp) begin bad++; $display("FAIL rand_read op=%0d addr=%h got=%h exp=%h", i, a, rd, exp); end
            end
        end
        total++; if (clash_seen) begin bad++; $display("FAIL rand_bus_clash got=1 exp=0"); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_masked_write();
        test_back_to_back();
        test_reset_mid_write();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
